// File: rtl/ball_physics.sv
// Single-axis bouncing-ball model: gravity, hand rebound, ceiling clamp and floor game-over,
// stepped once per physics tick from a free-running divider.
module ball_physics #(
  parameter int unsigned PW       = 9,
  parameter int unsigned VW       = 8,
  parameter int unsigned TICK_DIV = 120000,
  parameter int unsigned Y_MIN    = 7,
  parameter int unsigned Y_MAX    = 317,
  parameter int unsigned HIT_WIN  = 8,
  parameter int unsigned V_STOP   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ball_release_button,
  input  logic [PW-1:0] home,
  input  logic [PW-1:0] handline,
  input  logic [VW-1:0] hand_velocity,
  input  logic [1:0]    k,
  output logic [PW-1:0] pos_y,
  output logic          tick,
  output logic [1:0]    beep_flag,
  output logic          stop_flag,
  output logic          over_flag
);
  localparam int unsigned CW   = $clog2(TICK_DIV + 1);
  localparam int unsigned SW   = PW + 2;
  localparam int unsigned VMAX = (1 << VW) - 1;

  localparam logic signed [VW+1:0] VLIM   = (VW+2)'(VMAX);
  localparam logic signed [SW-1:0] HW_S   = SW'(HIT_WIN);
  localparam logic signed [SW-1:0] YMIN_S = SW'(Y_MIN);
  localparam logic signed [SW-1:0] YMAX_S = SW'(Y_MAX);

  localparam logic [1:0] BEEP_NONE = 2'b00;
  localparam logic [1:0] BEEP_HIT  = 2'b01;
  localparam logic [1:0] BEEP_CEIL = 2'b10;
  localparam logic [1:0] BEEP_OVER = 2'b11;

  typedef enum logic [1:0] {HOLD, FALL, REST, OVER} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt;
  logic signed [VW:0]   vel, v_nxt;
  logic [PW-1:0]        y_nxt;
  logic [1:0]           beep_nxt;

  logic signed [VW+1:0] v_add;
  logic signed [VW:0]   v_phys;
  logic signed [SW-1:0] y_sum, diff, adiff;
  logic [VW-1:0]        vmag, reb;
  logic [VW+1:0]        scaled;
  logic [VW:0]          reb_sum;
  logic [PW-1:0]        rest_pos;
  logic                 hit, floor_hit, ceil_hit;

  // Physics tick divider
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CW'(TICK_DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CW'(1);
      tick <= 1'b0;
    end
  end

  // Candidate motion for this tick and the event tests on it
  always_comb begin
    v_add = {vel[VW], vel} + {{VW{1'b0}}, k} + (VW+2)'(1);
    if (v_add > VLIM)       v_phys = (VW+1)'(VLIM);
    else if (v_add < -VLIM) v_phys = (VW+1)'(-VLIM);
    else                    v_phys = (VW+1)'(v_add);

    y_sum = $signed({2'b00, pos_y}) + $signed({{(SW-VW-1){v_phys[VW]}}, v_phys});
    diff  = y_sum - $signed({2'b00, handline});
    adiff = diff[SW-1] ? -diff : diff;

    hit       = !v_phys[VW] && (v_phys != '0) && (adiff <= HW_S);
    floor_hit = (y_sum >= YMAX_S);
    ceil_hit  = (y_sum <= YMIN_S);

    vmag    = v_phys[VW] ? VW'(-v_phys) : VW'(v_phys);
    scaled  = {2'b00, vmag} * (VW+2)'(3'd4 - {1'b0, k});
    reb_sum = (VW+1)'(scaled >> 2) + {1'b0, hand_velocity};
    reb     = (reb_sum > (VW+1)'(VMAX)) ? VW'(VMAX) : reb_sum[VW-1:0];

    rest_pos = (handline < PW'(HIT_WIN)) ? PW'(Y_MIN) : handline - PW'(HIT_WIN);
  end

  // Next-state and next-value selection; a dropped button wins over every tick event
  always_comb begin
    state_nxt = state;
    y_nxt     = pos_y;
    v_nxt     = vel;
    beep_nxt  = tick ? BEEP_NONE : beep_flag;
    unique case (state)
      HOLD: begin
        y_nxt = home;
        v_nxt = '0;
        if (tick && ball_release_button) state_nxt = FALL;
      end
      FALL: begin
        if (tick) begin
          if (hit) begin
            y_nxt    = rest_pos;
            beep_nxt = BEEP_HIT;
            if (reb < VW'(V_STOP)) begin
              v_nxt     = '0;
              state_nxt = REST;
            end else begin
              v_nxt = -$signed({1'b0, reb});
            end
          end else if (floor_hit) begin
            y_nxt     = PW'(Y_MAX);
            v_nxt     = '0;
            beep_nxt  = BEEP_OVER;
            state_nxt = OVER;
          end else if (ceil_hit) begin
            y_nxt    = PW'(Y_MIN);
            v_nxt    = '0;
            beep_nxt = BEEP_CEIL;
          end else begin
            y_nxt = y_sum[PW-1:0];
            v_nxt = v_phys;
          end
        end
      end
      REST: begin
        if (tick) begin
          y_nxt = rest_pos;
          v_nxt = '0;
          if (hand_velocity >= VW'(V_STOP)) begin
            v_nxt     = -$signed({1'b0, hand_velocity});
            state_nxt = FALL;
          end
        end
      end
      OVER: begin
        y_nxt = pos_y;
      end
      default: state_nxt = HOLD;
    endcase
    if (tick && !ball_release_button) begin
      state_nxt = HOLD;
      y_nxt     = home;
      v_nxt     = '0;
      beep_nxt  = BEEP_NONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HOLD;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_y     <= '0;
      vel       <= '0;
      beep_flag <= BEEP_NONE;
      stop_flag <= 1'b0;
      over_flag <= 1'b0;
    end else begin
      pos_y     <= y_nxt;
      vel       <= v_nxt;
      beep_flag <= beep_nxt;
      stop_flag <= (state_nxt == REST);
      over_flag <= (state_nxt == OVER);
    end
  end

endmodule

// File: tb/tb_ball_physics.sv
// Directed bench for ball_physics with a 4-cycle physics tick; expected positions are hand-derived.
module tb_ball_physics;
  logic       clk = 1'b0;
  logic       rst;
  logic       button;
  logic [8:0] home, handline;
  logic [7:0] hv;
  logic [1:0] k;
  logic [8:0] pos_y;
  logic       tick;
  logic [1:0] beep_flag;
  logic       stop_flag, over_flag;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ball_physics #(.PW(9), .VW(8), .TICK_DIV(4)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .ball_release_button (button),
    .home                (home),
    .handline            (handline),
    .hand_velocity       (hv),
    .k                   (k),
    .pos_y               (pos_y),
    .tick                (tick),
    .beep_flag           (beep_flag),
    .stop_flag           (stop_flag),
    .over_flag           (over_flag)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance to just after the next physics-update edge
  task automatic next_tick();
    int n = 0;
    @(negedge clk);
    while (tick !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    chk("tick_seen", 32'(tick), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; button = 1'b0; home = 9'd50; handline = 9'd300; hv = 8'd0; k = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pos", 32'(pos_y), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_beep", 32'(beep_flag), 32'd0);
    chk("rst_stop", 32'(stop_flag), 32'd0);
    chk("rst_over", 32'(over_flag), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("hold_home", 32'(pos_y), 32'd50);
    repeat (2) @(posedge clk);
    #1;
    chk("tick_low", 32'(tick), 32'd0);
    @(posedge clk); #1;
    chk("tick_pulse", 32'(tick), 32'd1);
    @(posedge clk); #1;
    chk("tick_one_cycle", 32'(tick), 32'd0);

    // Plain fall, k=0
    button = 1'b1;
    next_tick(); chk("rel_pos", 32'(pos_y), 32'd50);
    next_tick(); chk("fall_t1", 32'(pos_y), 32'd51);
    next_tick(); chk("fall_t2", 32'(pos_y), 32'd53);
    next_tick(); chk("fall_t3", 32'(pos_y), 32'd56);
    button = 1'b0;
    next_tick(); chk("drop_home", 32'(pos_y), 32'd50);

    // Hand hit: v_next=10, y_next=295, hv=3 -> 292, v=-13
    home = 9'd240; hv = 8'd3; button = 1'b1;
    next_tick();
    repeat (9) next_tick();
    chk("pre_hit", 32'(pos_y), 32'd285);
    next_tick();
    chk("hit_pos", 32'(pos_y), 32'd292);
    chk("hit_beep", 32'(beep_flag), 32'd1);
    next_tick();
    chk("rebound_pos", 32'(pos_y), 32'd280);
    chk("hit_beep_clr", 32'(beep_flag), 32'd0);
    button = 1'b0;
    next_tick();

    // Saturated rebound then ceiling
    hv = 8'd255; button = 1'b1;
    next_tick();
    repeat (10) next_tick();
    chk("hit2_pos", 32'(pos_y), 32'd292);
    next_tick(); chk("sat_pos", 32'(pos_y), 32'd38);
    next_tick();
    chk("ceil_pos", 32'(pos_y), 32'd7);
    chk("ceil_beep", 32'(beep_flag), 32'd2);
    next_tick();
    chk("ceil_after", 32'(pos_y), 32'd8);
    chk("ceil_beep_clr", 32'(beep_flag), 32'd0);
    button = 1'b0;
    next_tick();

    // Button dropped on the hit tick
    hv = 8'd3; button = 1'b1;
    next_tick();
    repeat (9) next_tick();
    button = 1'b0;
    next_tick();
    chk("drop_hit_pos", 32'(pos_y), 32'd240);
    chk("drop_hit_beep", 32'(beep_flag), 32'd0);

    // Weak rebound -> REST, then relaunch by the hand
    home = 9'd292; k = 2'd3; hv = 8'd0; button = 1'b1;
    next_tick();
    next_tick();
    chk("rest_pos", 32'(pos_y), 32'd292);
    chk("rest_stop", 32'(stop_flag), 32'd1);
    chk("rest_beep", 32'(beep_flag), 32'd1);
    handline = 9'd310;
    next_tick();
    chk("rest_follow", 32'(pos_y), 32'd302);
    chk("rest_stop2", 32'(stop_flag), 32'd1);
    hv = 8'd5;
    next_tick();
    chk("launch_pos", 32'(pos_y), 32'd302);
    chk("launch_stop", 32'(stop_flag), 32'd0);
    next_tick();
    chk("launch_v", 32'(pos_y), 32'd301);
    button = 1'b0;
    next_tick();

    // Hand below HIT_WIN: rest position clamps to Y_MIN
    home = 9'd0; k = 2'd0; handline = 9'd4; hv = 8'd0; button = 1'b1;
    next_tick();
    next_tick();
    chk("clamp_pos", 32'(pos_y), 32'd7);
    chk("clamp_stop", 32'(stop_flag), 32'd1);
    button = 1'b0;
    next_tick();

    // Floor -> OVER
    home = 9'd50; k = 2'd3; handline = 9'd0; button = 1'b1;
    next_tick();
    repeat (11) next_tick();
    chk("pre_floor", 32'(pos_y), 32'd314);
    chk("pre_floor_over", 32'(over_flag), 32'd0);
    next_tick();
    chk("floor_pos", 32'(pos_y), 32'd317);
    chk("floor_beep", 32'(beep_flag), 32'd3);
    chk("floor_over", 32'(over_flag), 32'd1);
    next_tick();
    chk("over_frozen", 32'(pos_y), 32'd317);
    chk("over_beep_clr", 32'(beep_flag), 32'd0);
    chk("over_stays", 32'(over_flag), 32'd1);
    button = 1'b0;
    next_tick();
    chk("over_exit_pos", 32'(pos_y), 32'd50);
    chk("over_exit_flag", 32'(over_flag), 32'd0);
    button = 1'b1;
    next_tick(); chk("refall_rel", 32'(pos_y), 32'd50);
    next_tick(); chk("refall_t1", 32'(pos_y), 32'd54);

    // Reset mid-flight
    rst = 1'b1;
    #2;
    chk("mid_rst_pos", 32'(pos_y), 32'd0);
    chk("mid_rst_tick", 32'(tick), 32'd0);
    chk("mid_rst_beep", 32'(beep_flag), 32'd0);
    chk("mid_rst_stop", 32'(stop_flag), 32'd0);
    chk("mid_rst_over", 32'(over_flag), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_home", 32'(pos_y), 32'd50);
    next_tick(); chk("post_rst_rel", 32'(pos_y), 32'd50);
    next_tick(); chk("post_rst_t1", 32'(pos_y), 32'd54);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
